// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch path.
package cpu_pkg;

  localparam int ADDR_W = 12;
  localparam int INSTR_W = 19;

  localparam logic [ADDR_W-1:0]  RESET_PC  = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 19'd0;

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential PC step; the address space simply wraps from 4095 to 0.
  function automatic logic [ADDR_W-1:0] nextPc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a response that arrives while decode is stalled.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // Flush beats load beats drain; the entry payload only changes on load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer in front of a 1-cycle registered instruction memory.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out
);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic               reqValid_q;
  logic               reqValid_d;
  logic [ADDR_W-1:0]  reqPc_q;
  logic [ADDR_W-1:0]  reqPc_d;

  logic               validOut_q;
  logic [INSTR_W-1:0] instrOut_q;
  logic [ADDR_W-1:0]  pcOut_q;

  logic               issue;
  logic               skidValid;
  logic               skidLoad;
  logic               skidDrain;
  fetch_entry_t       skidEntry;
  fetch_entry_t       respEntry;
  fetch_entry_t       outEntry_d;

  assign issue = !stall && !redirect;

  // Next PC and request tracking; a redirect wins over everything and kills the in-flight read.
  always_comb begin
    pc_d       = pc_q;
    reqValid_d = 1'b0;
    reqPc_d    = reqPc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d       = nextPc(pc_q);
      reqValid_d = 1'b1;
      reqPc_d    = pc_q;
    end
  end

  // PC and outstanding-request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      reqValid_q <= 1'b0;
      reqPc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      reqValid_q <= reqValid_d;
      reqPc_q    <= reqPc_d;
    end
  end

  assign respEntry = '{instr: instruction_in, pc: reqPc_q};

  // A response landing during a stall is parked; the parked entry goes out first once decode accepts.
  assign skidLoad  = stall && reqValid_q && !redirect;
  assign skidDrain = !stall && skidValid && !redirect;

  fetch_skid_buffer u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (skidLoad),
    .drain_i (skidDrain),
    .flush_i (redirect),
    .entry_i (respEntry),
    .valid_o (skidValid),
    .entry_o (skidEntry)
  );

  // Output source select: the older skid entry always precedes the live memory response.
  always_comb begin
    outEntry_d = respEntry;
    if (skidValid) begin
      outEntry_d = skidEntry;
    end
  end

  // Decode-facing output register; holds under stall, clears valid on redirect or when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      validOut_q <= 1'b0;
      instrOut_q <= NOP_INSTR;
      pcOut_q    <= '0;
    end else if (redirect) begin
      validOut_q <= 1'b0;
    end else if (!stall) begin
      if (skidValid || reqValid_q) begin
        validOut_q <= 1'b1;
        instrOut_q <= outEntry_d.instr;
        pcOut_q    <= outEntry_d.pc;
      end else begin
        validOut_q <= 1'b0;
      end
    end
  end

  // A stall cycle issues nothing, so a response can never arrive while the skid is occupied.
  assert property (@(posedge clock) disable iff (!reset_n) !(skidValid && reqValid_q && stall));

  assign address         = pc_q;
  assign instruction_out = instrOut_q;
  assign pc_out          = pcOut_q;
  assign valid_out       = validOut_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: model memory, in-order delivery reference model, directed and random traffic.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               stall = 1'b0;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic [INSTR_W-1:0] instruction_in = '0;
  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] instruction_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               valid_out;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [INSTR_W-1:0] mem [0:4095];

  // Reference model: what the decode stage must see, described as a fetch stream
  typedef struct {
    int instr;
    int pc;
  } entry_t;

  int     mPc;
  bit     mInflight;
  int     mInflightPc;
  entry_t mPending[$];
  bit     mOutValid;
  int     mOutInstr;
  int     mOutPc;

  fetch_unit dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .address         (address),
    .instruction_in  (instruction_in),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // instructionMemory stand-in: registered read, one cycle of latency
  always @(posedge clock) instruction_in <= mem[address];

  task automatic compare(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc       = int'(RESET_PC);
    mInflight = 1'b0;
    mPending.delete();
    mOutValid = 1'b0;
    mOutInstr = 0;
    mOutPc    = 0;
  endtask

  // Advance the model by one clock edge given the inputs that were applied during the cycle
  task automatic modelStep(input bit st, input bit rd, input int rpc);
    bit respValid;
    int respPc;
    entry_t e;
    respValid = mInflight;
    respPc    = mInflightPc;
    if (rd) begin
      mOutValid = 1'b0;
      mPending.delete();
      mInflight = 1'b0;
      mPc       = rpc;
    end else if (!st) begin
      if (mPending.size() > 0) begin
        e = mPending.pop_front();
        mOutValid = 1'b1;
        mOutInstr = e.instr;
        mOutPc    = e.pc;
      end else if (respValid) begin
        mOutValid = 1'b1;
        mOutInstr = int'(mem[respPc]);
        mOutPc    = respPc;
      end else begin
        mOutValid = 1'b0;
      end
      mInflight   = 1'b1;
      mInflightPc = mPc;
      mPc         = (mPc + 1) % 4096;
    end else begin
      if (respValid) begin
        compare("parked_entries_before_park", mPending.size(), 0);
        e.instr = int'(mem[respPc]);
        e.pc    = respPc;
        mPending.push_back(e);
      end
      mInflight = 1'b0;
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model
  task automatic checkOutput();
    compare("address", int'(address), mPc);
    compare("valid_out", int'(valid_out), int'(mOutValid));
    if (mOutValid) begin
      compare("instruction_out", int'(instruction_out), mOutInstr);
      compare("pc_out", int'(pc_out), mOutPc);
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then step the model at the edge
  task automatic applyStimulus(input bit st, input bit rd, input int rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = ADDR_W'(rpc);
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    modelStep(st, rd, rpc);
    #1;
  endtask

  task automatic expectValid(input string name, input int instr, input int pc);
    compare({name, "_valid"}, int'(valid_out), 1);
    compare({name, "_instr"}, int'(instruction_out), instr);
    compare({name, "_pc"}, int'(pc_out), pc);
  endtask

  task automatic expectIdle(input string name);
    compare({name, "_valid"}, int'(valid_out), 0);
  endtask

  // Asynchronous reset entry (checked before any edge) and release just after a rising edge
  task automatic doReset();
    stall    = 1'b0;
    redirect = 1'b0;
    reset_n  = 1'b0;
    #1;
    compare("rst_valid_out", int'(valid_out), 0);
    compare("rst_address", int'(address), int'(RESET_PC));
    compare("rst_pc_out", int'(pc_out), 0);
    compare("rst_instr_out", int'(instruction_out), 0);
    modelReset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = INSTR_W'($urandom);
    mem[0]    = 19'd25;
    mem[1]    = 19'd23;
    mem[2]    = 19'd20;
    mem[3]    = 19'd12;
    mem[100]  = 19'd30;
    mem[101]  = 19'd31;
    mem[4095] = 19'd7;
    modelReset();
    #2;

    $display("[TB] straight-line fetch after reset");
    doReset();
    applyStimulus(0, 0, 0);
    expectIdle("s1_cycle1");
    applyStimulus(0, 0, 0);
    expectValid("s1_cycle2", 25, 0);
    applyStimulus(0, 0, 0);
    expectValid("s1_cycle3", 23, 1);
    applyStimulus(0, 0, 0);
    expectValid("s1_cycle4", 20, 2);

    $display("[TB] single-cycle stall with parked response");
    doReset();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    expectValid("s2_hold", 25, 0);
    applyStimulus(0, 0, 0);
    expectValid("s2_parked", 23, 1);
    applyStimulus(0, 0, 0);
    expectValid("s2_next", 20, 2);
    applyStimulus(0, 0, 0);
    expectValid("s2_after", 12, 3);

    $display("[TB] redirect with a request in flight");
    doReset();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 100);
    expectIdle("s3_bubble1");
    applyStimulus(0, 0, 0);
    expectIdle("s3_bubble2");
    applyStimulus(0, 0, 0);
    expectValid("s3_target", 30, 100);
    applyStimulus(0, 0, 0);
    expectValid("s3_target_next", 31, 101);

    $display("[TB] redirect while stalled with a parked entry");
    doReset();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 100);
    expectIdle("s4_flushed");
    applyStimulus(0, 0, 0);
    expectIdle("s4_bubble");
    applyStimulus(0, 0, 0);
    expectValid("s4_target", 30, 100);

    $display("[TB] PC wrap at the top of the address space");
    doReset();
    applyStimulus(0, 1, 4095);
    compare("s5_addr_top", int'(address), 4095);
    applyStimulus(0, 0, 0);
    compare("s5_addr_wrap", int'(address), 0);
    applyStimulus(0, 0, 0);
    expectValid("s5_top", 7, 4095);
    applyStimulus(0, 0, 0);
    expectValid("s5_wrapped", 25, 0);

    $display("[TB] reset in the middle of a stream");
    applyStimulus(1, 0, 0);
    doReset();
    applyStimulus(0, 0, 0);
    expectIdle("s6_cycle1");
    applyStimulus(0, 0, 0);
    expectValid("s6_cycle2", 25, 0);
    applyStimulus(0, 0, 0);
    expectValid("s6_cycle3", 23, 1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit st;
      bit rd;
      int rpc;
      r   = int'($urandom_range(0, 199));
      st  = (int'($urandom_range(0, 99)) < 30);
      rd  = (int'($urandom_range(0, 99)) < 8);
      rpc = ($urandom_range(0, 3) == 0) ? 4090 + int'($urandom_range(0, 5))
                                        : int'($urandom_range(0, 4095));
      if (rpc > 4095) rpc = rpc - 4096;
      if (r == 0) begin
        doReset();
      end else begin
        applyStimulus(st, rd, rpc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
